epoch_feature_extractor: RTL and testbench

- First feature-extraction stage, directly downstream of the preprocessor.
- Consumes the filtered sample stream (out_signal/valid) and the epoch-restart pulse (new_sample_flag).
- Accumulates one epoch of EPOCH_LENGTH valid samples into five time-domain features: MAV sum, energy, zero crossings, max and min.
- Presents the features on a valid/ready output held until consumed by the classifier front end.

---
 rtl/epoch_feature_extractor_if.sv | 29 ++
 rtl/epoch_feature_extractor.sv | 188 ++++++++++++++++++
 tb/tb_epoch_feature_extractor.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/epoch_feature_extractor_if.sv
// Feature-extractor bus: filtered sample stream in, feature set out on valid/ready.
// slave = extractor side, master = producer/consumer side.
interface epoch_feature_extractor_if #(
    parameter int unsigned EPOCH_LENGTH = 256,
    parameter int unsigned ACC_W        = 40
);
    localparam int unsigned ZC_W = $clog2(EPOCH_LENGTH);

    logic [31:0]      in_signal;
    logic             in_valid;
    logic             new_sample_flag;
    logic             feat_ready;
    logic             feat_valid;
    logic [ACC_W-1:0] mav_sum;
    logic [ACC_W-1:0] energy;
    logic [ZC_W-1:0]  zero_cross;
    logic [31:0]      peak_max;
    logic [31:0]      peak_min;

    modport slave (
        input  in_signal, in_valid, new_sample_flag, feat_ready,
        output feat_valid, mav_sum, energy, zero_cross, peak_max, peak_min
    );

    modport master (
        output in_signal, in_valid, new_sample_flag, feat_ready,
        input  feat_valid, mav_sum, energy, zero_cross, peak_max, peak_min
    );
endinterface

// File: rtl/epoch_feature_extractor.sv
// Accumulates one epoch of valid samples into MAV sum, energy, zero crossings and
// signed peaks, then presents the set on a valid/ready output held until consumed.
module epoch_feature_extractor #(
    parameter int unsigned EPOCH_LENGTH = 256,
    parameter int unsigned SQ_SHIFT     = 12,
    parameter int unsigned ACC_W        = 40
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    epoch_feature_extractor_if.slave        bus,
    output logic                            overrun
);
    localparam int unsigned CNT_W = $clog2(EPOCH_LENGTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   mav_acc_q, mav_acc_d;
    logic [ACC_W-1:0]   en_acc_q, en_acc_d;
    logic [CNT_W-1:0]   zc_acc_q, zc_acc_d;
    logic signed [31:0] max_acc_q, max_acc_d;
    logic signed [31:0] min_acc_q, min_acc_d;
    logic               prev_sign_q, prev_sign_d;

    logic               feat_valid_q, feat_valid_d;
    logic [ACC_W-1:0]   mav_out_q, mav_out_d;
    logic [ACC_W-1:0]   en_out_q, en_out_d;
    logic [CNT_W-1:0]   zc_out_q, zc_out_d;
    logic [31:0]        max_out_q, max_out_d;
    logic [31:0]        min_out_q, min_out_d;
    logic               overrun_q, overrun_d;

    logic signed [31:0] x, x_shift, s_ext, sq_s;
    logic [31:0]        abs_x;
    logic signed [15:0] s_sat;
    logic               first_sample, last_sample;

    always_comb begin
        x       = signed'(bus.in_signal);
        abs_x   = x[31] ? (~bus.in_signal + 32'd1) : bus.in_signal;
        x_shift = x >>> SQ_SHIFT;
        if (x_shift > 32'sd32767) begin
            s_sat = 16'sh7FFF;
        end else if (x_shift < -32'sd32768) begin
            s_sat = 16'sh8000;
        end else begin
            s_sat = x_shift[15:0];
        end
        s_ext        = {{16{s_sat[15]}}, s_sat};
        sq_s         = s_ext * s_ext;
        first_sample = (cnt_q == '0);
        last_sample  = (cnt_q == CNT_W'(EPOCH_LENGTH - 1));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mav_acc_d    = mav_acc_q;
        en_acc_d     = en_acc_q;
        zc_acc_d     = zc_acc_q;
        max_acc_d    = max_acc_q;
        min_acc_d    = min_acc_q;
        prev_sign_d  = prev_sign_q;
        feat_valid_d = feat_valid_q;
        mav_out_d    = mav_out_q;
        en_out_d     = en_out_q;
        zc_out_d     = zc_out_q;
        max_out_d    = max_out_q;
        min_out_d    = min_out_q;
        overrun_d    = overrun_q;

        if (!enable) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            mav_acc_d    = '0;
            en_acc_d     = '0;
            zc_acc_d     = '0;
            max_acc_d    = '0;
            min_acc_d    = '0;
            prev_sign_d  = 1'b0;
            feat_valid_d = 1'b0;
            mav_out_d    = '0;
            en_out_d     = '0;
            zc_out_d     = '0;
            max_out_d    = '0;
            min_out_d    = '0;
            overrun_d    = 1'b0;
        end else begin
            if (feat_valid_q && bus.feat_ready) begin
                feat_valid_d = 1'b0;
            end
            // Restart flag and DONE both clear the epoch; DONE additionally publishes it.
            if (bus.new_sample_flag || state_q == ST_DONE) begin
                cnt_d       = '0;
                mav_acc_d   = '0;
                en_acc_d    = '0;
                zc_acc_d    = '0;
                max_acc_d   = '0;
                min_acc_d   = '0;
                prev_sign_d = 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (!bus.new_sample_flag && bus.in_valid) begin
                        cnt_d       = cnt_q + 1'b1;
                        mav_acc_d   = mav_acc_q + ACC_W'(abs_x);
                        en_acc_d    = en_acc_q + ACC_W'(unsigned'(sq_s));
                        prev_sign_d = x[31];
                        if (first_sample) begin
                            max_acc_d = x;
                            min_acc_d = x;
                        end else begin
                            if (x[31] != prev_sign_q) zc_acc_d = zc_acc_q + 1'b1;
                            if (x > max_acc_q) max_acc_d = x;
                            if (x < min_acc_q) min_acc_d = x;
                        end
                        if (last_sample) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_ACCUM;
                    if (!bus.new_sample_flag) begin
                        if (!feat_valid_q || bus.feat_ready) begin
                            feat_valid_d = 1'b1;
                            mav_out_d    = mav_acc_q;
                            en_out_d     = en_acc_q;
                            zc_out_d     = zc_acc_q;
                            max_out_d    = max_acc_q;
                            min_out_d    = min_acc_q;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mav_acc_q    <= '0;
            en_acc_q     <= '0;
            zc_acc_q     <= '0;
            max_acc_q    <= '0;
            min_acc_q    <= '0;
            prev_sign_q  <= 1'b0;
            feat_valid_q <= 1'b0;
            mav_out_q    <= '0;
            en_out_q     <= '0;
            zc_out_q     <= '0;
            max_out_q    <= '0;
            min_out_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mav_acc_q    <= mav_acc_d;
            en_acc_q     <= en_acc_d;
            zc_acc_q     <= zc_acc_d;
            max_acc_q    <= max_acc_d;
            min_acc_q    <= min_acc_d;
            prev_sign_q  <= prev_sign_d;
            feat_valid_q <= feat_valid_d;
            mav_out_q    <= mav_out_d;
            en_out_q     <= en_out_d;
            zc_out_q     <= zc_out_d;
            max_out_q    <= max_out_d;
            min_out_q    <= min_out_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.feat_valid = feat_valid_q;
    assign bus.mav_sum    = mav_out_q;
    assign bus.energy     = en_out_q;
    assign bus.zero_cross = zc_out_q;
    assign bus.peak_max   = max_out_q;
    assign bus.peak_min   = min_out_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_epoch_feature_extractor.sv
// Directed bench for epoch_feature_extractor (EPOCH_LENGTH=256, SQ_SHIFT=0, ACC_W=40).
module tb_epoch_feature_extractor;
    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic overrun;
    int   errors = 0;
    int   checks = 0;

    epoch_feature_extractor_if #(.EPOCH_LENGTH(256), .ACC_W(40)) bus ();

    epoch_feature_extractor #(
        .EPOCH_LENGTH(256),
        .SQ_SHIFT    (0),
        .ACC_W       (40)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives n valid samples alternating a, b (starting with a), one per cycle.
    task automatic feed(input logic [31:0] a, input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_signal       = (i % 2 == 0) ? a : b;
            bus.in_valid        = 1'b1;
            bus.new_sample_flag = 1'b0;
        end
    endtask

    task automatic gap();
        @(negedge clk);
        bus.in_valid        = 1'b0;
        bus.new_sample_flag = 1'b0;
    endtask

    initial begin
        rst_n               = 1'b0;
        enable              = 1'b0;
        bus.in_signal       = '0;
        bus.in_valid        = 1'b0;
        bus.new_sample_flag = 1'b0;
        bus.feat_ready      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_fv", bus.feat_valid, 0);
        chk("rst_mav", bus.mav_sum, 0);
        chk("rst_en", bus.energy, 0);
        chk("rst_zc", bus.zero_cross, 0);
        chk("rst_max", bus.peak_max, 0);
        chk("rst_min", bus.peak_min, 0);
        chk("rst_ovr", overrun, 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // 1: constant +100
        feed(32'd100, 32'd100, 256);
        gap();
        chk("t1_lat_early", bus.feat_valid, 0);
        @(negedge clk);
        chk("t1_fv", bus.feat_valid, 1);
        chk("t1_mav", bus.mav_sum, 25600);
        chk("t1_en", bus.energy, 2560000);
        chk("t1_zc", bus.zero_cross, 0);
        chk("t1_max", bus.peak_max, 100);
        chk("t1_min", bus.peak_min, 100);
        bus.feat_ready = 1'b1;
        @(negedge clk);
        chk("t1_fv_fall", bus.feat_valid, 0);
        bus.feat_ready = 1'b0;

        // 2: alternating +5/-5
        feed(32'd5, 32'hFFFF_FFFB, 256);
        gap();
        @(negedge clk);
        chk("t2_fv", bus.feat_valid, 1);
        chk("t2_zc", bus.zero_cross, 255);
        chk("t2_mav", bus.mav_sum, 1280);
        chk("t2_en", bus.energy, 6400);
        chk("t2_max", bus.peak_max, 5);
        chk("t2_min", bus.peak_min, 32'hFFFF_FFFB);
        bus.feat_ready = 1'b1;
        @(negedge clk);
        bus.feat_ready = 1'b0;

        // 3: full-scale positive, then most-negative
        feed(32'h7FFF_FFFF, 32'h7FFF_FFFF, 256);
        gap();
        @(negedge clk);
        chk("t3a_mav", bus.mav_sum, 64'd549755813632);
        chk("t3a_en", bus.energy, 64'd274861129984);
        chk("t3a_max", bus.peak_max, 32'h7FFF_FFFF);
        bus.feat_ready = 1'b1;
        @(negedge clk);
        bus.feat_ready = 1'b0;
        feed(32'h8000_0000, 32'h8000_0000, 256);
        gap();
        @(negedge clk);
        chk("t3b_mav", bus.mav_sum, 64'd549755813888);
        chk("t3b_en", bus.energy, 64'd274877906944);
        chk("t3b_min", bus.peak_min, 32'h8000_0000);
        chk("t3b_zc", bus.zero_cross, 0);
        bus.feat_ready = 1'b1;
        @(negedge clk);
        bus.feat_ready = 1'b0;

        // 4: partial epoch aborted; the flagged sample is dropped
        feed(32'd9, 32'd9, 100);
        @(negedge clk);
        bus.in_signal       = 32'd50;
        bus.in_valid        = 1'b1;
        bus.new_sample_flag = 1'b1;
        feed(32'd1, 32'd1, 256);
        chk("t4_no_partial", bus.feat_valid, 0);
        gap();
        @(negedge clk);
        chk("t4_fv", bus.feat_valid, 1);
        chk("t4_mav", bus.mav_sum, 256);
        chk("t4_zc", bus.zero_cross, 0);
        chk("t4_max", bus.peak_max, 1);
        bus.feat_ready = 1'b1;
        @(negedge clk);
        bus.feat_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_single", bus.feat_valid, 0);

        // 5: result held across a second epoch, overrun set
        feed(32'd3, 32'd3, 256);
        gap();
        @(negedge clk);
        chk("t5_fv1", bus.feat_valid, 1);
        chk("t5_ovr0", overrun, 0);
        feed(32'd4, 32'd4, 256);
        gap();
        @(negedge clk);
        chk("t5_fv_hold", bus.feat_valid, 1);
        chk("t5_mav_hold", bus.mav_sum, 768);
        chk("t5_ovr1", overrun, 1);
        bus.feat_ready = 1'b1;
        @(negedge clk);
        chk("t5_fv_fall", bus.feat_valid, 0);
        chk("t5_ovr_sticky", overrun, 1);
        bus.feat_ready = 1'b0;

        // 6: asynchronous reset mid-epoch
        feed(32'd11, 32'd11, 150);
        gap();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ovr", overrun, 0);
        chk("t6_rst_mav", bus.mav_sum, 0);
        chk("t6_rst_max", bus.peak_max, 0);
        @(negedge clk);
        rst_n = 1'b1;
        feed(32'hFFFF_FFFA, 32'hFFFF_FFFA, 256);
        gap();
        @(negedge clk);
        chk("t6_fv", bus.feat_valid, 1);
        chk("t6_mav", bus.mav_sum, 1536);
        chk("t6_en", bus.energy, 9216);
        chk("t6_max", bus.peak_max, 32'hFFFF_FFFA);
        chk("t6_min", bus.peak_min, 32'hFFFF_FFFA);

        // enable low acts as a soft clear of the held result
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("clr_fv", bus.feat_valid, 0);
        chk("clr_mav", bus.mav_sum, 0);
        enable = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
